// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a FIFO of payload words feeding a start/data/parity/stop
// serializer with back-to-back frames and a registered, idle-high serial line.
module uart_tx_buffered #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_serial
);
    // state    | meaning
    // S_IDLE   | line high, waiting for a buffered word
    // S_START  | start bit (low)
    // S_DATA   | payload bits, LSB first
    // S_PARITY | parity bit (only when PARITY_MODE != 0)
    // S_STOP   | STOP_BITS high bits; may chain straight into the next frame
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [NW-1:0]         nbit_q, nbit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, head;
    logic                  parity_q, parity_d, tx_q, tx_d;
    logic                  pop, wr_accept, bit_end;

    assign head      = mem_q[rd_ptr_q];
    assign wr_accept = wr_en && !full_q;
    assign bit_end   = (baud_q == '0);

    always_comb begin
        wr_ptr_d   = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == CW'(FIFO_DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = wr_en && full_q;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            nbit_q     <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            nbit_q     <= nbit_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        nbit_d   = nbit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = BAUD_RELOAD;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = BAUD_RELOAD;
                    nbit_d  = NW'(DATA_WIDTH - 1);
                end else baud_d = baud_q - BW'(1);
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = shift_q >> 1;
                    if (nbit_q == '0) begin
                        if (PARITY_MODE != 0) state_d = S_PARITY;
                        else begin
                            state_d = S_STOP;
                            nbit_d  = NW'(STOP_BITS - 1);
                        end
                    end else nbit_d = nbit_q - NW'(1);
                end else baud_d = baud_q - BW'(1);
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    baud_d  = BAUD_RELOAD;
                    nbit_d  = NW'(STOP_BITS - 1);
                end else baud_d = baud_q - BW'(1);
            end
            S_STOP: begin
                if (!bit_end) baud_d = baud_q - BW'(1);
                else if (nbit_q != '0) begin
                    nbit_d = nbit_q - NW'(1);
                    baud_d = BAUD_RELOAD;
                end else if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            shift_d  = head;
            parity_d = (^head) ^ (PARITY_MODE == 2);
        end
    end

    // The line is registered, so it is driven from the next-state view of the frame.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign tx_serial = tx_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: default, 4-deep, even- and odd-parity instances
// share one stimulus stream; each test resets all of them first.
module tb_uart_tx_buffered;
    logic       clk, areset, wr_en;
    logic [7:0] wr_data;

    logic       full_m, empty_m, overflow_m, busy_m, tx_m;
    logic [4:0] count_m;
    logic       full_s, empty_s, overflow_s, busy_s, tx_s;
    logic [2:0] count_s;
    logic       full_e, empty_e, overflow_e, busy_e, tx_e;
    logic [4:0] count_e;
    logic       full_o, empty_o, overflow_o, busy_o, tx_o;
    logic [4:0] count_o;

    int n_checks = 0;
    int n_errors = 0;
    int ovf_s_cnt = 0;
    logic line_m[$], line_s[$], line_e[$], line_o[$];

    uart_tx_buffered u_main (
        .clk(clk), .areset(areset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_m), .empty(empty_m), .count(count_m), .overflow(overflow_m),
        .busy(busy_m), .tx_serial(tx_m));

    uart_tx_buffered #(.FIFO_DEPTH(4)) u_small (
        .clk(clk), .areset(areset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_s), .empty(empty_s), .count(count_s), .overflow(overflow_s),
        .busy(busy_s), .tx_serial(tx_s));

    uart_tx_buffered #(.PARITY_MODE(1), .STOP_BITS(2)) u_even (
        .clk(clk), .areset(areset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_e), .empty(empty_e), .count(count_e), .overflow(overflow_e),
        .busy(busy_e), .tx_serial(tx_e));

    uart_tx_buffered #(.PARITY_MODE(2), .STOP_BITS(2)) u_odd (
        .clk(clk), .areset(areset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_o), .empty(empty_o), .count(count_o), .overflow(overflow_o),
        .busy(busy_o), .tx_serial(tx_o));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; samples every line on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        line_m.push_back(tx_m);
        line_s.push_back(tx_s);
        line_e.push_back(tx_e);
        line_o.push_back(tx_o);
        if (overflow_s === 1'b1) ovf_s_cnt++;
    endtask

    task automatic clear_lines();
        line_m.delete(); line_s.delete(); line_e.delete(); line_o.delete();
    endtask

    function automatic logic sample(input int sel, input int idx);
        logic v;
        v = 1'bx;
        case (sel)
            0: if (idx < line_m.size()) v = line_m[idx];
            1: if (idx < line_s.size()) v = line_s[idx];
            2: if (idx < line_e.size()) v = line_e[idx];
            default: if (idx < line_o.size()) v = line_o[idx];
        endcase
        return v;
    endfunction

    // Each bit must read its value for all 16 cycles of its slot; par < 0 means no parity bit.
    task automatic check_frame(input int sel, input int start, input logic [7:0] data,
                               input int par, input int stops, input string tag);
        logic exp_bits[12];
        int   nb;
        int   highs;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = data[i];
        nb = 9;
        if (par >= 0) begin
            exp_bits[nb] = par[0];
            nb++;
        end
        for (int s = 0; s < stops; s++) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            highs = 0;
            for (int c = 0; c < 16; c++)
                if (sample(sel, start + b*16 + c) === 1'b1) highs++;
            check_val($sformatf("%s_bit%0d", tag, b), highs, exp_bits[b] ? 16 : 0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        areset = 1'b1;
        wr_en  = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        clear_lines();
        ovf_s_cnt = 0;
    endtask

    // wr_data is scrambled right after acceptance; the frame must not see it.
    task automatic do_write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        wr_data = 8'hFF;
    endtask

    initial begin
        int exp_cnt[6];
        int exp_full[6];
        int exp_ovf[6];
        logic [7:0] burst[6];
        logic [7:0] fill[4];

        areset  = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        #1;
        check_val("rst_tx_m", tx_m, 1);         check_val("rst_busy_m", busy_m, 0);
        check_val("rst_full_m", full_m, 0);     check_val("rst_empty_m", empty_m, 1);
        check_val("rst_count_m", count_m, 0);   check_val("rst_ovf_m", overflow_m, 0);
        check_val("rst_tx_s", tx_s, 1);         check_val("rst_busy_s", busy_s, 0);
        check_val("rst_full_s", full_s, 0);     check_val("rst_empty_s", empty_s, 1);
        check_val("rst_count_s", count_s, 0);   check_val("rst_ovf_s", overflow_s, 0);
        check_val("rst_tx_e", tx_e, 1);         check_val("rst_busy_e", busy_e, 0);
        check_val("rst_full_e", full_e, 0);     check_val("rst_empty_e", empty_e, 1);
        check_val("rst_count_e", count_e, 0);   check_val("rst_ovf_e", overflow_e, 0);
        check_val("rst_tx_o", tx_o, 1);         check_val("rst_busy_o", busy_o, 0);
        check_val("rst_full_o", full_o, 0);     check_val("rst_empty_o", empty_o, 1);
        check_val("rst_count_o", count_o, 0);   check_val("rst_ovf_o", overflow_o, 0);

        // Single 0xA5 frame from idle, written at the first edge after reset release.
        apply_reset();
        do_write(8'hA5);
        check_val("a5_empty", empty_m, 0);
        check_val("a5_count", count_m, 1);
        check_val("a5_busy_pre", busy_m, 0);
        check_val("a5_tx_pre", tx_m, 1);
        clear_lines();
        repeat (160) tick();
        check_val("a5_busy_last", busy_m, 1);
        tick();
        check_val("a5_busy_end", busy_m, 0);
        check_val("a5_tx_end", tx_m, 1);
        check_val("a5_empty_end", empty_m, 1);
        check_frame(0, 0, 8'hA5, -1, 1, "a5");

        // Three consecutive writes: frames chain with no gap.
        apply_reset();
        wr_en = 1'b1;
        wr_data = 8'h3C;
        tick();
        check_val("b3_count0", count_m, 1);
        clear_lines();
        wr_data = 8'h81;
        tick();
        check_val("b3_count1", count_m, 1);
        check_val("b3_tx_start", tx_m, 0);
        wr_data = 8'h5A;
        tick();
        check_val("b3_count2", count_m, 2);
        wr_en = 1'b0;
        wr_data = 8'hFF;
        while (line_m.size() < 480) begin
            tick();
            if (line_m.size() == 160) check_val("b3_count160", count_m, 2);
            if (line_m.size() == 161) check_val("b3_count161", count_m, 1);
            if (line_m.size() == 320) check_val("b3_count320", count_m, 1);
            if (line_m.size() == 321) check_val("b3_count321", count_m, 0);
        end
        check_val("b3_busy_last", busy_m, 1);
        tick();
        check_val("b3_busy_end", busy_m, 0);
        check_frame(0, 0,   8'h3C, -1, 1, "b3_f0");
        check_frame(0, 160, 8'h81, -1, 1, "b3_f1");
        check_frame(0, 320, 8'h5A, -1, 1, "b3_f2");

        // Depth-4 instance: six writes while busy, two rejected.
        apply_reset();
        do_write(8'h11);
        clear_lines();
        repeat (20) tick();
        burst    = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        exp_cnt  = '{1, 2, 3, 4, 4, 4};
        exp_full = '{0, 0, 0, 1, 1, 1};
        exp_ovf  = '{0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = burst[i];
            tick();
            check_val($sformatf("d4_count%0d", i), count_s, exp_cnt[i]);
            check_val($sformatf("d4_full%0d", i), full_s, exp_full[i]);
            check_val($sformatf("d4_ovf%0d", i), overflow_s, exp_ovf[i]);
        end
        wr_en = 1'b0;
        tick();
        check_val("d4_ovf_after", overflow_s, 0);
        check_val("d4_count_after", count_s, 4);
        while (line_s.size() < 800) tick();
        check_val("d4_busy_last", busy_s, 1);
        tick();
        check_val("d4_busy_end", busy_s, 0);
        check_val("d4_empty_end", empty_s, 1);
        check_val("d4_ovf_pulses", ovf_s_cnt, 2);
        check_frame(1, 0,   8'h11, -1, 1, "d4_f0");
        check_frame(1, 160, 8'h22, -1, 1, "d4_f1");
        check_frame(1, 320, 8'h33, -1, 1, "d4_f2");
        check_frame(1, 480, 8'h44, -1, 1, "d4_f3");
        check_frame(1, 640, 8'h55, -1, 1, "d4_f4");

        // Parity instances, two stop bits, payload 0x07 (three ones).
        apply_reset();
        do_write(8'h07);
        clear_lines();
        repeat (192) tick();
        check_val("par_busy_last_e", busy_e, 1);
        check_val("par_busy_last_o", busy_o, 1);
        tick();
        check_val("par_busy_end_e", busy_e, 0);
        check_val("par_busy_end_o", busy_o, 0);
        check_frame(2, 0, 8'h07, 1, 2, "even");
        check_frame(3, 0, 8'h07, 0, 2, "odd");

        // Write while full, coinciding with the pop at the end of the first frame.
        apply_reset();
        do_write(8'hA1);
        clear_lines();
        fill = '{8'hB2, 8'hC3, 8'hD4, 8'hE5};
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = fill[i];
            tick();
        end
        wr_en = 1'b0;
        check_val("fp_count_full", count_s, 4);
        check_val("fp_full", full_s, 1);
        while (line_s.size() < 160) tick();
        check_val("fp_count_pre", count_s, 4);
        check_val("fp_busy_pre", busy_s, 1);
        wr_en   = 1'b1;
        wr_data = 8'hF6;
        tick();
        wr_en   = 1'b0;
        check_val("fp_ovf", overflow_s, 1);
        check_val("fp_count_post", count_s, 3);
        check_val("fp_full_post", full_s, 0);
        tick();
        check_val("fp_ovf_clear", overflow_s, 0);
        while (line_s.size() < 320) tick();
        check_val("fp_count_320", count_s, 3);
        check_frame(1, 0,   8'hA1, -1, 1, "fp_f0");
        check_frame(1, 160, 8'hB2, -1, 1, "fp_f1");

        // Reset in the middle of a data bit with two words still queued.
        apply_reset();
        wr_en = 1'b1;
        wr_data = 8'h5A;
        tick();
        wr_data = 8'h69;
        tick();
        wr_data = 8'h78;
        tick();
        wr_en = 1'b0;
        repeat (40) tick();
        check_val("mr_count_pre", count_m, 2);
        check_val("mr_busy_pre", busy_m, 1);
        areset = 1'b1;
        #1;
        check_val("mr_tx", tx_m, 1);
        check_val("mr_empty", empty_m, 1);
        check_val("mr_count", count_m, 0);
        check_val("mr_busy", busy_m, 0);
        tick();
        areset = 1'b0;
        do_write(8'hC3);
        clear_lines();
        repeat (160) tick();
        tick();
        check_val("mr_busy_end", busy_m, 0);
        check_val("mr_empty_end", empty_m, 1);
        check_frame(0, 0, 8'hC3, -1, 1, "mr_f0");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
